// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue.
// Entry layout and the predictor training packet.
package branch_resolve_queue_pkg;
    localparam int N            = 2;
    localparam int BRQ_DEPTH    = 16;
    localparam int BRQ_IDX_BITS = $clog2(BRQ_DEPTH);

    typedef logic [31:0] ADDR;

    typedef struct packed {
        logic valid;
        logic resolved;
        ADDR  pc;
        logic pred_taken;
        ADDR  pred_target;
        logic act_taken;
        ADDR  act_target;
    } BRQ_ENTRY;

    typedef struct packed {
        logic valid;
        ADDR  PC;
        logic resolve_taken;
        ADDR  resolve_target;
    } ROB_IF_ENTRY;

    typedef struct packed {
        ROB_IF_ENTRY [N-1:0] entries;
    } ROB_IF_PACKET;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/commit bundle of the branch resolve queue.
// slave is the queue side, master the pipeline side.
interface branch_resolve_queue_if;
    import branch_resolve_queue_pkg::*;

    logic [N-1:0]                   alloc_valid;
    ADDR  [N-1:0]                   alloc_pc;
    logic [N-1:0]                   alloc_pred_taken;
    ADDR  [N-1:0]                   alloc_pred_target;
    logic                           alloc_ready;
    logic [N-1:0][BRQ_IDX_BITS-1:0] alloc_idx;
    logic [N-1:0]                   res_valid;
    logic [N-1:0][BRQ_IDX_BITS-1:0] res_idx;
    logic [N-1:0]                   res_taken;
    ADDR  [N-1:0]                   res_target;
    logic [N-1:0]                   commit_valid;
    ROB_IF_PACKET                   rob_if_packet;
    logic                           mispredict;
    ADDR                            redirect_pc;
    logic [BRQ_IDX_BITS:0]          count;

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred_taken,
        input  alloc_pred_target, res_valid, res_idx,
        input  res_taken, res_target, commit_valid,
        output alloc_ready, alloc_idx, rob_if_packet,
        output mispredict, redirect_pc, count
    );

    modport master (
        output alloc_valid, alloc_pc, alloc_pred_taken,
        output alloc_pred_target, res_valid, res_idx,
        output res_taken, res_target, commit_valid,
        input  alloc_ready, alloc_idx, rob_if_packet,
        input  mispredict, redirect_pc, count
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches, resolved out of order,
// retired in order; flushes itself on a mispredicted commit.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
(
    input logic clock,
    input logic reset,
    branch_resolve_queue_if.slave bus
);
    localparam int IDX_W = BRQ_IDX_BITS;
    localparam int CW    = IDX_W + 1;

    BRQ_ENTRY         q [BRQ_DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    n_alloc;
    logic [CW-1:0]    n_ret;
    logic [N-1:0]     ret;
    logic             stop;
    logic             mp;
    ADDR              mp_pc;
    BRQ_ENTRY         ce;
    ROB_IF_PACKET     pkt_n;

    function automatic logic is_mispred(BRQ_ENTRY e);
        return (e.act_taken != e.pred_taken) ||
               (e.act_taken && e.act_target != e.pred_target);
    endfunction

    assign bus.alloc_ready = (CW'(BRQ_DEPTH) - cnt) >= CW'(N);
    assign bus.count       = cnt;

    always_comb begin
        n_alloc = '0;
        for (int i = 0; i < N; i++) begin
            bus.alloc_idx[i] = tail + IDX_W'(n_alloc);
            if (bus.alloc_valid[i]) n_alloc = n_alloc + CW'(1);
        end
    end

    // Retire a prefix of lanes, stopping after the first mispredict.
    always_comb begin
        n_ret = '0;
        ret   = '0;
        stop  = 1'b0;
        mp    = 1'b0;
        mp_pc = '0;
        pkt_n = '0;
        ce    = '0;
        for (int k = 0; k < N; k++) begin
            ce = q[head + IDX_W'(k)];
            if (!bus.commit_valid[k]) stop = 1'b1;
            if (!stop) begin
                ret[k] = 1'b1;
                n_ret  = n_ret + CW'(1);
                pkt_n.entries[k].valid          = 1'b1;
                pkt_n.entries[k].PC             = ce.pc;
                pkt_n.entries[k].resolve_taken  = ce.act_taken;
                pkt_n.entries[k].resolve_target = ce.act_target;
                if (is_mispred(ce)) begin
                    stop  = 1'b1;
                    mp    = 1'b1;
                    mp_pc = ce.act_taken ? ce.act_target : ce.pc + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BRQ_DEPTH; i++) q[i] <= '0;
            head              <= '0;
            tail              <= '0;
            cnt               <= '0;
            bus.rob_if_packet <= '0;
            bus.mispredict    <= 1'b0;
            bus.redirect_pc   <= '0;
        end else begin
            bus.rob_if_packet <= pkt_n;
            bus.mispredict    <= mp;
            bus.redirect_pc   <= mp_pc;
            head              <= head + IDX_W'(n_ret);
            if (mp) begin
                for (int i = 0; i < BRQ_DEPTH; i++) q[i].valid <= 1'b0;
                tail <= head + IDX_W'(n_ret);
                cnt  <= '0;
            end else begin
                if (bus.alloc_ready) begin
                    for (int i = 0; i < N; i++) begin
                        if (bus.alloc_valid[i]) begin
                            q[bus.alloc_idx[i]] <= '{
                                valid:       1'b1,
                                resolved:    1'b0,
                                pc:          bus.alloc_pc[i],
                                pred_taken:  bus.alloc_pred_taken[i],
                                pred_target: bus.alloc_pred_target[i],
                                act_taken:   1'b0,
                                act_target:  '0
                            };
                        end
                    end
                    tail <= tail + IDX_W'(n_alloc);
                end
                // Later lanes override earlier ones on the same slot.
                for (int i = 0; i < N; i++) begin
                    if (bus.res_valid[i] && q[bus.res_idx[i]].valid) begin
                        q[bus.res_idx[i]].resolved   <= 1'b1;
                        q[bus.res_idx[i]].act_taken  <= bus.res_taken[i];
                        q[bus.res_idx[i]].act_target <= bus.res_target[i];
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (ret[k]) q[head + IDX_W'(k)].valid <= 1'b0;
                end
                cnt <= cnt + (bus.alloc_ready ? n_alloc : '0) - n_ret;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with a scoreboard
// of expected training packets checked the cycle after commit.
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    typedef struct packed {
        ROB_IF_PACKET pkt;
        logic         mp;
        ADDR          rpc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];

    branch_resolve_queue_if bus();

    branch_resolve_queue dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(string tag, logic [135:0] obs, logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ROB_IF_ENTRY ent(logic v, ADDR pc, logic t, ADDR tg);
        ROB_IF_ENTRY e;
        e.valid          = v;
        e.PC             = pc;
        e.resolve_taken  = t;
        e.resolve_target = tg;
        return e;
    endfunction

    function automatic ADDR pcn(int n);
        return ADDR'(32'h1000 + 16 * n);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        bus.alloc_valid       = '0;
        bus.alloc_pc          = '0;
        bus.alloc_pred_taken  = '0;
        bus.alloc_pred_target = '0;
        bus.res_valid         = '0;
        bus.res_idx           = '0;
        bus.res_taken         = '0;
        bus.res_target        = '0;
        bus.commit_valid      = '0;
    endtask

    task automatic al(int l, ADDR pc, logic pt, ADDR tg);
        bus.alloc_valid[l]       = 1'b1;
        bus.alloc_pc[l]          = pc;
        bus.alloc_pred_taken[l]  = pt;
        bus.alloc_pred_target[l] = tg;
    endtask

    task automatic rs(int l, int idx, logic t, ADDR tg);
        bus.res_valid[l]  = 1'b1;
        bus.res_idx[l]    = BRQ_IDX_BITS'(idx);
        bus.res_taken[l]  = t;
        bus.res_target[l] = tg;
    endtask

    task automatic expect_commit(ROB_IF_ENTRY e0, ROB_IF_ENTRY e1,
                                 logic mp, ADDR rpc);
        exp_t x;
        x.pkt.entries[0] = e0;
        x.pkt.entries[1] = e1;
        x.mp             = mp;
        x.rpc            = rpc;
        sb.push_back(x);
    endtask

    task automatic sb_check;
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            x = sb.pop_front();
            chk("rob_if_packet", 136'(bus.rob_if_packet), 136'(x.pkt));
            chk("mispredict", 136'(bus.mispredict), 136'(x.mp));
            if (x.mp) chk("redirect_pc", 136'(bus.redirect_pc), 136'(x.rpc));
        end
    endtask

    task automatic chk_cnt(string tag, int c);
        chk(tag, 136'(bus.count), 136'(c));
    endtask

    task automatic chk_idx(string tag, int l, int idx);
        chk(tag, 136'(bus.alloc_idx[l]), 136'(idx));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_cnt("reset_count", 0);
        chk("reset_ready", 136'(bus.alloc_ready), 136'(1));
        chk("reset_mp", 136'(bus.mispredict), 136'(0));
        chk("reset_pkt", 136'(bus.rob_if_packet), 136'(0));
        chk("reset_rpc", 136'(bus.redirect_pc), 136'(0));

        // two-lane allocation
        al(0, 32'h100, 1'b0, 32'h104);
        al(1, 32'h200, 1'b1, 32'h400);
        #1;
        chk_idx("t1_idx0", 0, 0);
        chk_idx("t1_idx1", 1, 1);
        tick();
        idle();
        chk_cnt("t1_count", 2);
        chk("t1_ready", 136'(bus.alloc_ready), 136'(1));

        // out-of-order resolve, clean commit
        rs(0, 1, 1'b1, 32'h400);
        tick();
        idle();
        rs(0, 0, 1'b0, 32'h0);
        tick();
        idle();
        bus.commit_valid = 2'b11;
        expect_commit(ent(1, 32'h100, 0, 0), ent(1, 32'h200, 1, 32'h400),
                      1'b0, 32'h0);
        tick();
        idle();
        sb_check();
        chk_cnt("t2_count", 0);

        // NT predicted, resolved taken: lane 1 squashed, alloc dropped
        al(0, 32'h300, 1'b0, 32'h304);
        al(1, 32'h310, 1'b0, 32'h314);
        #1;
        chk_idx("t3_idx0", 0, 2);
        chk_idx("t3_idx1", 1, 3);
        tick();
        idle();
        rs(0, 2, 1'b1, 32'h500);
        rs(1, 3, 1'b0, 32'h0);
        tick();
        idle();
        bus.commit_valid = 2'b11;
        al(0, 32'h999, 1'b0, 32'h99d);
        expect_commit(ent(1, 32'h300, 1, 32'h500), ent(0, 0, 0, 0),
                      1'b1, 32'h500);
        tick();
        idle();
        sb_check();
        chk_cnt("t3_count", 0);

        // wrong target
        al(0, 32'h580, 1'b1, 32'h600);
        #1;
        chk_idx("t4_idx_after_flush", 0, 3);
        tick();
        idle();
        chk("t4_mp_low", 136'(bus.mispredict), 136'(0));
        rs(0, 3, 1'b1, 32'h680);
        tick();
        idle();
        bus.commit_valid = 2'b01;
        expect_commit(ent(1, 32'h580, 1, 32'h680), ent(0, 0, 0, 0),
                      1'b1, 32'h680);
        tick();
        idle();
        sb_check();

        // predicted T, resolved NT -> pc+4
        al(0, 32'h700, 1'b1, 32'h800);
        #1;
        chk_idx("t4b_idx", 0, 4);
        tick();
        idle();
        rs(0, 4, 1'b0, 32'h0);
        tick();
        idle();
        bus.commit_valid = 2'b01;
        expect_commit(ent(1, 32'h700, 0, 0), ent(0, 0, 0, 0),
                      1'b1, 32'h704);
        tick();
        idle();
        sb_check();
        chk_cnt("t4b_count", 0);

        // fill to 15 from tail=5, wrapping past slot 15
        for (int n = 0; n < 14; n += 2) begin
            idle();
            al(0, pcn(n), 1'b0, pcn(n) + 32'd4);
            al(1, pcn(n + 1), 1'b0, pcn(n + 1) + 32'd4);
            #1;
            chk_idx("t5_fill_idx0", 0, (5 + n) % 16);
            chk_idx("t5_fill_idx1", 1, (6 + n) % 16);
            tick();
        end
        idle();
        al(0, pcn(14), 1'b0, pcn(14) + 32'd4);
        tick();
        idle();
        chk_cnt("t5_full_count", 15);
        chk("t5_ready_low", 136'(bus.alloc_ready), 136'(0));
        al(0, 32'hfff0, 1'b0, 32'hfff4);
        al(1, 32'hfff8, 1'b0, 32'hfffc);
        tick();
        idle();
        chk_cnt("t5_dropped_count", 15);

        rs(0, 5, 1'b0, 32'h0);
        rs(1, 6, 1'b0, 32'h0);
        tick();
        idle();
        bus.commit_valid = 2'b11;
        expect_commit(ent(1, pcn(0), 0, 0), ent(1, pcn(1), 0, 0),
                      1'b0, 32'h0);
        tick();
        idle();
        sb_check();
        chk_cnt("t5_after_commit", 13);
        chk("t5_ready_high", 136'(bus.alloc_ready), 136'(1));

        // same-slot resolve: lane 1 must win (matches prediction)
        rs(0, 7, 1'b1, 32'hbad0);
        rs(1, 7, 1'b0, 32'h0);
        tick();
        idle();
        rs(0, 8, 1'b0, 32'h0);
        tick();
        idle();
        bus.commit_valid = 2'b11;
        al(0, pcn(15), 1'b0, pcn(15) + 32'd4);
        al(1, pcn(16), 1'b0, pcn(16) + 32'd4);
        #1;
        chk_idx("t5_wrap_idx0", 0, 4);
        chk_idx("t5_wrap_idx1", 1, 5);
        expect_commit(ent(1, pcn(2), 0, 0), ent(1, pcn(3), 0, 0),
                      1'b0, 32'h0);
        tick();
        idle();
        sb_check();
        chk_cnt("t5_alloc_commit", 13);

        // reset during a pending mispredicting commit
        rs(0, 9, 1'b1, 32'hdead);
        tick();
        idle();
        bus.commit_valid = 2'b01;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk_cnt("t6_count", 0);
        chk("t6_mp", 136'(bus.mispredict), 136'(0));
        chk("t6_pkt", 136'(bus.rob_if_packet), 136'(0));
        chk("t6_ready", 136'(bus.alloc_ready), 136'(1));
        al(0, 32'h100, 1'b0, 32'h104);
        #1;
        chk_idx("t6_idx", 0, 0);
        idle();
        chk("sb_drained", 136'(sb.size()), 136'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
